// File: rtl/encoder4_2_stream.sv
// encoder4_2_stream: streams the 2-bit index of every set line of a 4-bit vector over valid/ready
module encoder4_2_stream #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_code,
    output logic       out_last,
    output logic       zero_err
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t     state, state_nxt;
    logic [3:0] pending, pending_nxt;
    logic [1:0] lo_idx, hi_idx;
    logic       accept, emit, zero_err_nxt;
    // pick the next line in scan order, derive handshakes, and compute the next pending set
    always_comb begin
        lo_idx       = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
        hi_idx       = pending[3] ? 2'd3 : pending[2] ? 2'd2 : pending[1] ? 2'd1 : 2'd0;
        out_valid    = state == DRAIN;
        out_code     = out_valid ? (MSB_FIRST ? hi_idx : lo_idx) : 2'd0;
        out_last     = out_valid && ((pending & (pending - 4'd1)) == 4'd0);
        in_ready     = !out_valid || (out_ready && out_last);
        accept       = in_valid && in_ready;
        emit         = out_valid && out_ready;
        pending_nxt  = accept ? in_vec : emit ? (pending & ~(4'b0001 << out_code)) : pending;
        state_nxt    = (pending_nxt != 4'd0) ? DRAIN : IDLE;
        zero_err_nxt = accept && (in_vec == 4'd0);
    end
    // state, remaining lines and the zero-vector pulse; reset drops any undelivered codes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= 4'd0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            zero_err <= zero_err_nxt;
        end
    end
endmodule

// File: tb/tb_encoder4_2_stream.sv
// tb_encoder4_2_stream: table-driven check of both scan orders plus reset corner cases
module tb_encoder4_2_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_vec = 4'd0;
    logic       out_ready = 1'b0;
    logic       in_ready0, out_valid0, out_last0, zero_err0;
    logic       in_ready1, out_valid1, out_last1, zero_err1;
    logic [1:0] out_code0, out_code1;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    encoder4_2_stream #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
        .out_valid(out_valid0), .out_ready(out_ready), .out_code(out_code0),
        .out_last(out_last0), .zero_err(zero_err0)
    );
    encoder4_2_stream #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
        .out_valid(out_valid1), .out_ready(out_ready), .out_code(out_code1),
        .out_last(out_last1), .zero_err(zero_err1)
    );

    typedef struct {
        logic       iv;
        logic [3:0] vec;
        logic       ordy;
        logic       ov;
        logic [1:0] code0;
        logic [1:0] code1;
        logic       last;
        logic       ir;
        logic       ze;
    } vec_t;

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic ov, input logic [1:0] c0, input logic [1:0] c1,
                             input logic last, input logic ir, input logic ze);
        check("out_valid0", idx, {3'd0, out_valid0}, {3'd0, ov});
        check("out_valid1", idx, {3'd0, out_valid1}, {3'd0, ov});
        check("out_code0", idx, {2'd0, out_code0}, {2'd0, c0});
        check("out_code1", idx, {2'd0, out_code1}, {2'd0, c1});
        check("out_last0", idx, {3'd0, out_last0}, {3'd0, last});
        check("out_last1", idx, {3'd0, out_last1}, {3'd0, last});
        check("in_ready0", idx, {3'd0, in_ready0}, {3'd0, ir});
        check("in_ready1", idx, {3'd0, in_ready1}, {3'd0, ir});
        check("zero_err0", idx, {3'd0, zero_err0}, {3'd0, ze});
        check("zero_err1", idx, {3'd0, zero_err1}, {3'd0, ze});
    endtask

    vec_t tbl[26];

    initial begin
        // iv   vec      ordy  ov    c0     c1     last  ir    ze
        tbl[0]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b1000, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
        for (int i = 10; i < 15; i++)
            tbl[i] = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 4'b0110, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 4'b1000, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 4'b1000, 1'b1, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[23] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[25] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};

        #3;
        check_all(100, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            in_vec    = tbl[i].vec;
            out_ready = tbl[i].ordy;
            #1;
            check_all(i, tbl[i].ov, tbl[i].code0, tbl[i].code1, tbl[i].last, tbl[i].ir, tbl[i].ze);
        end

        // reset in the middle of draining 1111: nothing left over afterwards
        @(negedge clk);
        in_valid = 1'b1; in_vec = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_vec = 4'b0000;
        #1;
        check_all(200, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_all(201, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all(202, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_all(203 + i, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        end

        // backpressure on the last code with a new vector waiting
        @(negedge clk);
        in_valid = 1'b1; in_vec = 4'b0100; out_ready = 1'b0;
        @(negedge clk);
        in_vec = 4'b0001;
        #1;
        check_all(300, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_all(301, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check_all(302, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_all(303, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check_all(304, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/encoder4_2_stream.md
# encoder4_2_stream

Streaming 4-to-2 encoder, the inverse of the team's 2-to-4 decoder. It accepts a 4-bit line vector over a valid/ready handshake and emits the 2-bit index of every asserted line, one code per output handshake, in a fixed scan order. The final code of each vector is flagged with `out_last`. It sits between line-level request sources and code-consuming logic, so a decoder → encoder loop returns the original code.

## Interface
Parameters:
- MSB_FIRST, default 0: scan order. 0 emits the lowest set index first; 1 emits the highest set index first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block accepts in_vec this cycle.
- in_vec  input  4  line vector; bit i corresponds to code i. Any number of bits may be set.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code this cycle.
- out_code  output  2  index of the current line.
- out_last  output  1  out_code is the final code of the current vector.
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- Internal state is `pending[3:0]`, the lines not yet emitted.
- States:
  - IDLE: pending == 0.
  - DRAIN: pending != 0.
- Outputs, combinational from pending:
  - out_valid = (pending != 0).
  - out_code = lowest set index of pending (MSB_FIRST=0) or highest set index (MSB_FIRST=1).
  - out_last = out_valid and exactly one bit of pending set.
  - When pending == 0: out_code = 0, out_last = 0.
- in_ready = (pending == 0) | (out_ready & out_last).
- Input accept (in_valid & in_ready):
  - pending <= in_vec. A nonzero vector moves to DRAIN.
  - in_vec == 0: pending stays 0, state stays IDLE, zero_err = 1 for the next cycle only, no code is emitted.
- Output handshake (out_valid & out_ready) with no accept in the same cycle: clear the emitted bit from pending. When the last bit clears, return to IDLE.
- Simultaneous last-code handshake and input accept: the new vector replaces pending. No idle bubble.
- in_vec is ignored while in_ready = 0. The source must hold in_valid and in_vec stable until accepted.
- Once out_valid rises, out_code and out_last hold stable until out_ready.
- zero_err is a registered output, 0 in every cycle other than the one after a zero-vector accept.

## Timing
- Reset (rst_n low, asynchronous):
  - pending = 0, zero_err = 0.
  - Hence out_valid = 0, out_code = 0, out_last = 0, in_ready = 1.
- Reset asserted mid-DRAIN discards all remaining codes. No further output after release until a new accept.
- Latency: vector accepted at edge N → first code valid after edge N (cycle N+1).
- A vector with k set bits (k = 1..4) occupies k output handshakes. With out_ready held high, that is k consecutive cycles.
- Throughput: one code per cycle with out_ready = 1 continuously. Single-bit vectors stream back-to-back at one vector per cycle.
- Backpressure: with out_ready = 0, pending, out_code and out_last hold indefinitely, and in_ready = 0 whenever pending != 0.
- Zero vector: accepted in one cycle, zero_err high in cycle N+1, in_ready stays 1 throughout.

## Test plan
- Reset then each single line: in_vec = 0001, 0010, 0100, 1000 with out_ready = 1 → out_code 0, 1, 2, 3 in consecutive cycles, out_last = 1 each, in_ready never low. Matches the 2-to-4 decoder's inverse.
- Multi-hot with MSB_FIRST = 0: in_vec = 1011 → codes 0, 1, 3 over 3 cycles, out_last only on 3. Then IDLE.
  - Same stimulus with MSB_FIRST = 1 → codes 3, 1, 0.
- Backpressure: in_vec = 1111, out_ready low for 5 cycles → out_code = 0 held, in_ready = 0. Then out_ready = 1 → codes 0, 1, 2, 3.
- Overlap: in_vec = 0110 followed immediately by 1000 with in_valid held → codes 1, 2, 3 in three consecutive cycles. The second vector is accepted on the cycle code 2 (out_last) handshakes.
- Zero vector: in_vec = 0000 accepted → zero_err pulses for exactly one cycle, out_valid stays 0.
- Reset mid-drain: in_vec = 1111, rst_n low after code 1 → out_valid = 0 immediately, in_ready = 1. No leftover codes after release.
